vga_frame_fetch: RTL and testbench

//  Frame-buffer fetch engine: the producer side of the VGA pixel FIFO, running in the memory/system clock domain.

---
 rtl/vga_pkg.sv | 21 ++
 rtl/vga_frame_fetch_chk.sv | 24 ++
 rtl/vga_frame_fetch.sv | 178 +++++++++++++++++
 tb/tb_vga_frame_fetch.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// vga_pkg
//   Types and defaults shared by the VGA frame-buffer path.
//   fetch_state_t : state of the frame fetch engine (IDLE, FETCH, DRAIN)
//   H_DISPLAY_DEF / V_DISPLAY_DEF : visible geometry, also used by the timing generator
//   frame_pixels() : pixel count of one visible frame
package vga_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  localparam int H_DISPLAY_DEF = 640;
  localparam int V_DISPLAY_DEF = 480;

  function automatic int frame_pixels(input int h, input int v);
    return h * v;
  endfunction

endpackage

// File: rtl/vga_frame_fetch_chk.sv
// vga_frame_fetch_chk
//   Property checker for the outstanding-read counter of vga_frame_fetch.
//   clk_sys, rst_sys : clock and async active-high reset of the fetch engine
//   outst            : current outstanding-read count
//   mem_rvalid       : memory read-data valid
module vga_frame_fetch_chk #(
  parameter int MAX_OUTST = 4,
  parameter int OW        = 3
) (
  input logic          clk_sys,
  input logic          rst_sys,
  input logic [OW-1:0] outst,
  input logic          mem_rvalid
);

  // The counter must never exceed the configured in-flight cap.
  a_outst_cap : assert property (@(posedge clk_sys) disable iff (rst_sys)
    outst <= OW'(MAX_OUTST));

  // A response with nothing in flight would underflow the counter.
  a_outst_underflow : assert property (@(posedge clk_sys) disable iff (rst_sys)
    !(mem_rvalid && (outst == {OW{1'b0}})));

endmodule

// File: rtl/vga_frame_fetch.sv
// vga_frame_fetch
//   Producer side of the VGA pixel FIFO in the clk_sys domain. Streams one frame
//   of sequential pixel reads from frame-buffer memory and writes the returned
//   pixels into the async FIFO write port, throttled by fifo_afull and an
//   outstanding-read cap so the FIFO cannot overflow.
// Ports
//   clk_sys, rst_sys          : clock, async active-high reset
//   enable, frame_start       : frame control (frame_start is a 1-cycle pulse)
//   mem_req/mem_addr/mem_ready: read request channel (combinational mem_req)
//   mem_rvalid/mem_rdata      : in-order read response channel
//   fifo_din/fifo_write       : registered FIFO write port
//   fifo_full/fifo_afull      : FIFO status
//   busy                      : engine not idle
//   overflow                  : sticky, a response arrived while the FIFO was full
module vga_frame_fetch
  import vga_pkg::*;
#(
  parameter int WIDTH     = 12,
  parameter int AWIDTH    = 19,
  parameter int H_DISPLAY = H_DISPLAY_DEF,
  parameter int V_DISPLAY = V_DISPLAY_DEF,
  parameter int BASE_ADDR = 0,
  parameter int MAX_OUTST = 4
) (
  input  logic              clk_sys,
  input  logic              rst_sys,
  input  logic              enable,
  input  logic              frame_start,
  output logic              mem_req,
  output logic [AWIDTH-1:0] mem_addr,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [WIDTH-1:0]  mem_rdata,
  output logic [WIDTH-1:0]  fifo_din,
  output logic              fifo_write,
  input  logic              fifo_full,
  input  logic              fifo_afull,
  output logic              busy,
  output logic              overflow
);

  localparam int PIXELS = frame_pixels(H_DISPLAY, V_DISPLAY);
  localparam int RW     = $clog2(PIXELS + 1);
  localparam int OW     = $clog2(MAX_OUTST + 1);

  localparam logic [AWIDTH-1:0] BASE_A = AWIDTH'(BASE_ADDR);
  localparam logic [RW-1:0]     PIX_R  = RW'(PIXELS);
  localparam logic [OW-1:0]     MAX_O  = OW'(MAX_OUTST);

  fetch_state_t      state_r, state_s;
  logic [AWIDTH-1:0] addr_r;
  logic [RW-1:0]     remaining_r;
  logic [OW-1:0]     outst_r;
  logic              fifo_write_r;
  logic [WIDTH-1:0]  fifo_din_r;
  logic              overflow_r;
  logic              req_s;
  logic              accept_s;
  logic              reload_s;

  // Request issue: only while fetching, pixels left, below the cap and FIFO has room.
  always_comb begin
    req_s    = (state_r == FETCH) && (remaining_r != {RW{1'b0}}) &&
               (outst_r < MAX_O) && !fifo_afull;
    accept_s = req_s && mem_ready;
  end

  // Next-state decode; reload_s restarts address and pixel count for a new frame.
  always_comb begin
    state_s  = state_r;
    reload_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (frame_start && enable) begin
          state_s  = FETCH;
          reload_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      FETCH: begin
        // A restart request wins over normal completion; stale reads must drain first.
        if (frame_start) begin
          state_s = DRAIN;
        end else if ((remaining_r == {RW{1'b0}}) && (outst_r == {OW{1'b0}})) begin
          state_s = IDLE;
        end else begin
          state_s = FETCH;
        end
      end
      DRAIN: begin
        if (outst_r == {OW{1'b0}}) begin
          if (enable) begin
            state_s  = FETCH;
            reload_s = 1'b1;
          end else begin
            state_s = IDLE;
          end
        end else begin
          state_s = DRAIN;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk_sys or posedge rst_sys) begin
    if (rst_sys) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Read address and pixels-remaining counter; no wrap inside a frame.
  always_ff @(posedge clk_sys or posedge rst_sys) begin
    if (rst_sys) begin
      addr_r      <= BASE_A;
      remaining_r <= {RW{1'b0}};
    end else if (reload_s) begin
      addr_r      <= BASE_A;
      remaining_r <= PIX_R;
    end else if (accept_s) begin
      addr_r      <= addr_r + {{(AWIDTH-1){1'b0}}, 1'b1};
      remaining_r <= remaining_r - {{(RW-1){1'b0}}, 1'b1};
    end else begin
      addr_r      <= addr_r;
      remaining_r <= remaining_r;
    end
  end

  // Outstanding reads: accepts minus responses; both in one cycle cancel.
  always_ff @(posedge clk_sys or posedge rst_sys) begin
    if (rst_sys) begin
      outst_r <= {OW{1'b0}};
    end else begin
      case ({accept_s, mem_rvalid})
        2'b10:   outst_r <= outst_r + {{(OW-1){1'b0}}, 1'b1};
        2'b01:   outst_r <= outst_r - {{(OW-1){1'b0}}, 1'b1};
        default: outst_r <= outst_r;
      endcase
    end
  end

  // Response path: forward read data one cycle later, discard stale data while draining.
  always_ff @(posedge clk_sys or posedge rst_sys) begin
    if (rst_sys) begin
      fifo_write_r <= 1'b0;
      fifo_din_r   <= {WIDTH{1'b0}};
      overflow_r   <= 1'b0;
    end else begin
      fifo_write_r <= mem_rvalid && (state_r != DRAIN) && !fifo_full;
      fifo_din_r   <= mem_rdata;
      overflow_r   <= overflow_r || (mem_rvalid && fifo_full && (state_r == FETCH));
    end
  end

  assign mem_req    = req_s;
  assign mem_addr   = addr_r;
  assign fifo_write = fifo_write_r;
  assign fifo_din   = fifo_din_r;
  assign overflow   = overflow_r;
  assign busy       = (state_r != IDLE);

  vga_frame_fetch_chk #(
    .MAX_OUTST (MAX_OUTST),
    .OW        (OW)
  ) u_chk (
    .clk_sys    (clk_sys),
    .rst_sys    (rst_sys),
    .outst      (outst_r),
    .mem_rvalid (mem_rvalid)
  );

endmodule

// File: tb/tb_vga_frame_fetch.sv
// Testbench for vga_frame_fetch with a small 4x2 frame. A memory responder
// returns rdata = address with a configurable latency; a frame-level model
// predicts every output on each falling edge.
module tb_vga_frame_fetch;

  localparam int WIDTH  = 12;
  localparam int AWIDTH = 19;
  localparam int H      = 4;
  localparam int V      = 2;
  localparam int PIX    = H * V;
  localparam int MAXO   = 4;

  logic              clk_sys     = 1'b0;
  logic              rst_sys     = 1'b1;
  logic              enable      = 1'b1;
  logic              frame_start = 1'b0;
  logic              mem_req;
  logic [AWIDTH-1:0] mem_addr;
  logic              mem_ready   = 1'b1;
  logic              mem_rvalid  = 1'b0;
  logic [WIDTH-1:0]  mem_rdata   = 12'h000;
  logic [WIDTH-1:0]  fifo_din;
  logic              fifo_write;
  logic              fifo_full   = 1'b0;
  logic              fifo_afull  = 1'b0;
  logic              busy;
  logic              overflow;

  vga_frame_fetch #(
    .WIDTH(WIDTH), .AWIDTH(AWIDTH), .H_DISPLAY(H), .V_DISPLAY(V),
    .BASE_ADDR(0), .MAX_OUTST(MAXO)
  ) dut (
    .clk_sys(clk_sys), .rst_sys(rst_sys), .enable(enable), .frame_start(frame_start),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .fifo_din(fifo_din), .fifo_write(fifo_write), .fifo_full(fifo_full),
    .fifo_afull(fifo_afull), .busy(busy), .overflow(overflow)
  );

  always #5 clk_sys = ~clk_sys;

  int n_chk = 0;
  int n_err = 0;
  bit done  = 1'b0;

  // memory responder state
  typedef struct {
    logic [AWIDTH-1:0] addr;
    int                due;
  } req_t;
  req_t              mq[$];
  int                cyc        = 0;
  int                resp_given = 0;
  int                resp_allow = 1000000;
  int                lat_max    = 1;
  logic              acc_n      = 1'b0;
  logic [AWIDTH-1:0] acc_addr_n = '0;

  // observation logs
  logic [AWIDTH-1:0] acc_log[$];
  logic [WIDTH-1:0]  wr_log[$];

  // Memory: in-order responses, rdata = address, one per accepted request.
  always @(posedge clk_sys or posedge rst_sys) begin
    if (rst_sys) begin
      mq.delete();
      resp_given = 0;
      mem_rvalid = 1'b0;
      mem_rdata  = 12'h000;
    end else begin
      cyc++;
      if (acc_n) mq.push_back('{addr: acc_addr_n, due: cyc + $urandom_range(1, lat_max)});
      #1;
      if (mq.size() > 0 && mq[0].due <= cyc && resp_given < resp_allow) begin
        mem_rvalid = 1'b1;
        mem_rdata  = WIDTH'(mq[0].addr);
        void'(mq.pop_front());
        resp_given++;
      end else begin
        mem_rvalid = 1'b0;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Frame-level model: phase 0 idle, 1 fetching, 2 discarding stale reads.
  task automatic monitor();
    int   m_phase = 0;
    int   m_addr = 0, m_issued = 0, m_outst = 0;
    bit   m_wr = 1'b0, m_ovf = 1'b0;
    logic [WIDTH-1:0] m_din = '0;
    bit   exp_req, acc, rv;
    int   pre_outst, pre_left;
    while (!done) begin
      @(negedge clk_sys);
      if (rst_sys) begin
        m_phase = 0; m_addr = 0; m_issued = 0; m_outst = 0; m_wr = 1'b0; m_ovf = 1'b0;
      end
      exp_req = (m_phase == 1) && (m_issued < PIX) && (m_outst < MAXO) && !fifo_afull;
      chk("mem_req", mem_req, exp_req);
      chk("mem_addr", mem_addr, m_addr);
      chk("busy", busy, m_phase != 0);
      chk("fifo_write", fifo_write, m_wr);
      if (m_wr) chk("fifo_din", fifo_din, m_din);
      chk("overflow", overflow, m_ovf);
      if (mem_req && mem_ready) acc_log.push_back(mem_addr);
      if (fifo_write) wr_log.push_back(fifo_din);
      acc_n      = mem_req && mem_ready && !rst_sys;
      acc_addr_n = mem_addr;
      if (!rst_sys) begin
        acc       = exp_req && mem_ready;
        rv        = mem_rvalid;
        m_wr      = rv && (m_phase != 2) && !fifo_full;
        m_din     = mem_rdata;
        if (rv && fifo_full && m_phase == 1) m_ovf = 1'b1;
        pre_outst = m_outst;
        pre_left  = PIX - m_issued;
        m_outst   = m_outst + int'(acc) - int'(rv);
        if (acc) begin m_addr++; m_issued++; end
        case (m_phase)
          0: if (frame_start && enable) begin m_phase = 1; m_addr = 0; m_issued = 0; end
          1: if (frame_start) m_phase = 2;
             else if (pre_left == 0 && pre_outst == 0) m_phase = 0;
          2: if (pre_outst == 0) begin
               if (enable) begin m_phase = 1; m_addr = 0; m_issued = 0; end
               else m_phase = 0;
             end
          default: m_phase = 0;
        endcase
      end
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk_sys); #1; end
  endtask

  task automatic pulse_start();
    frame_start = 1'b1;
    step(1);
    frame_start = 1'b0;
  endtask

  task automatic wait_idle(input string nm, input int budget);
    int k = 0;
    while (busy && k < budget) begin step(1); k++; end
    chk(nm, busy, 1'b0);
  endtask

  task automatic wait_wr(input string nm, input int n, input int budget);
    int k = 0;
    while (wr_log.size() < n && k < budget) begin step(1); k++; end
    chk(nm, wr_log.size() >= n, 1'b1);
  endtask

  task automatic wait_acc(input string nm, input int n, input int budget);
    int k = 0;
    while (acc_log.size() < n && k < budget) begin step(1); k++; end
    chk(nm, acc_log.size() >= n, 1'b1);
  endtask

  task automatic clear_logs();
    acc_log.delete();
    wr_log.delete();
  endtask

  task automatic stimulus();
    int a0;
    step(3);
    rst_sys = 1'b0;
    step(2);

    // 1: basic frame
    clear_logs();
    pulse_start();
    wait_idle("t1_idle", 200);
    chk("t1_acc_count", acc_log.size(), 32'd8);
    chk("t1_wr_count", wr_log.size(), 32'd8);
    for (int i = 0; i < 8; i++) begin
      chk("t1_acc_addr", acc_log[i], i);
      chk("t1_wr_data", wr_log[i], i);
    end

    // 2: backpressure via fifo_afull
    clear_logs();
    pulse_start();
    wait_wr("t2_three_writes", 3, 100);
    fifo_afull = 1'b1;
    a0 = acc_log.size();
    step(8);
    chk("t2_req_held", mem_req, 1'b0);
    chk("t2_no_accepts", acc_log.size(), a0);
    fifo_afull = 1'b0;
    wait_idle("t2_idle", 200);
    chk("t2_wr_count", wr_log.size(), 32'd8);
    for (int i = 0; i < 8; i++) chk("t2_acc_addr", acc_log[i], i);
    chk("t2_overflow", overflow, 1'b0);

    // 3: outstanding cap with responses withheld
    clear_logs();
    resp_allow = resp_given;
    pulse_start();
    step(10);
    chk("t3_acc_count", acc_log.size(), 32'd4);
    for (int i = 0; i < 4; i++) chk("t3_acc_addr", acc_log[i], i);
    chk("t3_req_low", mem_req, 1'b0);
    resp_allow = 1000000;
    wait_idle("t3_idle", 200);
    chk("t3_wr_count", wr_log.size(), 32'd8);

    // 4: mid-frame restart with two stale responses in flight
    clear_logs();
    resp_allow = resp_given + 1;
    pulse_start();
    wait_acc("t4_three_acc", 3, 50);
    mem_ready = 1'b0;
    wait_wr("t4_one_wr", 1, 50);
    pulse_start();
    mem_ready  = 1'b1;
    resp_allow = 1000000;
    wait_idle("t4_idle", 300);
    chk("t4_acc_count", acc_log.size(), 32'd11);
    chk("t4_wr_count", wr_log.size(), 32'd9);
    chk("t4_first_wr", wr_log[0], 32'd0);
    for (int i = 0; i < 8; i++) begin
      chk("t4_acc_addr", acc_log[3+i], i);
      chk("t4_wr_data", wr_log[1+i], i);
    end

    // 5: overflow while fifo_full
    clear_logs();
    pulse_start();
    wait_wr("t5_two_wr", 2, 50);
    fifo_full = 1'b1;
    step(4);
    fifo_full = 1'b0;
    chk("t5_overflow_set", overflow, 1'b1);
    wait_idle("t5_idle", 200);
    chk("t5_overflow_sticky", overflow, 1'b1);
    chk("t5_dropped", wr_log.size() < 8, 1'b1);

    // 6: asynchronous reset mid-frame
    clear_logs();
    pulse_start();
    wait_acc("t6_two_acc", 2, 50);
    #2;
    rst_sys = 1'b1;
    #1;
    chk("t6_req", mem_req, 1'b0);
    chk("t6_busy", busy, 1'b0);
    chk("t6_addr", mem_addr, 32'd0);
    chk("t6_ovf_clear", overflow, 1'b0);
    step(2);
    rst_sys = 1'b0;
    enable  = 1'b0;
    a0 = acc_log.size();
    pulse_start();
    step(3);
    chk("t6_stay_idle", busy, 1'b0);
    chk("t6_no_acc", acc_log.size(), a0);
    enable = 1'b1;

    // randomized traffic
    lat_max = 4;
    for (int c = 0; c < 3000; c++) begin
      mem_ready   = ($urandom_range(0, 3) != 0);
      fifo_afull  = ($urandom_range(0, 4) == 0);
      fifo_full   = ($urandom_range(0, 80) == 0);
      enable      = ($urandom_range(0, 7) != 0);
      frame_start = ($urandom_range(0, 15) == 0);
      step(1);
    end
    frame_start = 1'b0;
    fifo_full   = 1'b0;
    fifo_afull  = 1'b0;
    mem_ready   = 1'b1;
    enable      = 1'b1;
    wait_idle("rand_settle", 500);

    // one clean frame after the random phase
    clear_logs();
    pulse_start();
    wait_idle("final_idle", 300);
    chk("final_wr_count", wr_log.size(), 32'd8);
    for (int i = 0; i < 8; i++) chk("final_wr_data", wr_log[i], i);
    done = 1'b1;
    step(2);
  endtask

  initial begin
    fork
      monitor();
      stimulus();
    join
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
